i2c_bus_conditioner: RTL
========================

Name: i2c_bus_conditioner

Overview:
Front-end stage directly upstream of i2c_slave_controller. It synchronises raw SDA/SCL pad inputs into the system clock domain and removes glitches shorter than a programmable length. It also produces single-cycle SCL edge strobes and START/repeated-START/STOP strobes, and tracks bus-busy state with a stuck-SCL-low timeout. The slave controller consumes these clean strobes instead of sampling raw pins.

Parameters:
FILTER_LEN, 3, number of consecutive clk cycles a synchronised line must hold a new level before the filtered output follows (legal range 1..15).
TIMEOUT_W, 16, width of the SCL-low timeout counter.
TIMEOUT_CYCLES, 16'd50000, clk cycles of SCL held low while busy before timeout fires (must be < 2^TIMEOUT_W).

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
sda_in  input  1  raw SDA pad level
scl_in  input  1  raw SCL pad level
sda_filt  output  1  synchronised, deglitched SDA
scl_filt  output  1  synchronised, deglitched SCL
scl_rise  output  1  1-cycle strobe: scl_filt went 0->1
scl_fall  output  1  1-cycle strobe: scl_filt went 1->0
start_det  output  1  1-cycle strobe: START or repeated START
rstart  output  1  qualifies start_det: 1 = repeated START (bus already busy)
stop_det  output  1  1-cycle strobe: STOP
bus_busy  output  1  level: between START and STOP/timeout
timeout  output  1  1-cycle strobe: SCL-low timeout expired

Behaviour:
- Reset (async assert, sync release): both sync flops, sda_filt, and scl_filt are set to 1 (idle bus); filter counters, all strobes, rstart, bus_busy, and timeout are cleared; the timeout counter is 0.
- Synchroniser: 2-flop chain per line.
- Filter (per line): a counter increments while the synchronised level differs from the filtered output and clears whenever they match. When the counter reaches FILTER_LEN-1 and the level still differs, the filtered output toggles and the counter clears. Pulses shorter than FILTER_LEN cycles never propagate. A clean input step reaches *_filt exactly 2+FILTER_LEN cycles later.
- Edge/condition detect: registered copies sda_q and scl_q of the filtered lines; all strobes are registered and assert in the cycle after the filtered change.
  - scl_rise = scl_filt & ~scl_q; scl_fall = ~scl_filt & scl_q.
  - START: sda falls while scl_filt = scl_q = 1. rstart = bus_busy at that moment.
  - STOP: sda rises while scl_filt = scl_q = 1.
  - If SDA and SCL filtered values change in the same cycle, only the SCL edge strobe fires; there is no START/STOP.
- bus_busy: set by START, cleared by STOP or timeout. A START while busy keeps it set.
- Timeout counter:
  - Counts while bus_busy = 1 and scl_filt = 0; clears on any scl edge or when not busy.
  - On reaching TIMEOUT_CYCLES-1: timeout pulses for 1 cycle, bus_busy clears, and the counter clears. No further timeout fires until a new START.
  - A STOP and a timeout in the same cycle: STOP strobe asserts, timeout is suppressed.
- Reset mid-transfer drops everything to the idle state immediately. The first edges after release are judged against the idle (1/1) filtered values, so a low line at release yields a single fall strobe once filtered.

Decomposition:
- Shared package i2c_pkg: I2C_IDLE_LEVEL (1'b1), DEVICE_ADDR default (7'b0101010), and the default FILTER_LEN and TIMEOUT_CYCLES constants reused by the top level.
- One sub-module i2c_glitch_filter (sync chain, counter, filtered output), instantiated once for SDA and once for SCL.
- Edge/condition/timeout logic lives in i2c_bus_conditioner.

Test Plan:
- Reset then idle-high inputs for 20 cycles -> sda_filt = scl_filt = 1, no strobes, bus_busy = 0.
- With FILTER_LEN=3, a 2-cycle low glitch on scl_in -> scl_filt stays 1, no scl_fall. A 3-cycle low pulse -> scl_filt falls 5 cycles after the input edge, plus one scl_fall strobe.
- With SCL high, drop SDA -> start_det = 1 for one cycle with rstart = 0, then bus_busy = 1. A second START before STOP -> start_det with rstart = 1. Raising SDA with SCL high -> stop_det pulse, then bus_busy = 0.
- Full byte write to address 0x2A (SCL 8 clk-cycle half-periods) -> exactly 9 scl_rise and 9 scl_fall strobes between start_det and stop_det, with no spurious START/STOP while SDA changes during SCL low.
- With TIMEOUT_CYCLES=64, START then hold SCL low -> timeout pulses after 64 low cycles and bus_busy drops. Re-raising SCL -> no second timeout.
- Assert rst_n low mid-byte while bus_busy = 1 -> all outputs return to their reset values asynchronously. After release with SDA/SCL high -> no strobes.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : i2c_pkg
//  Brief   : Shared constants for the I2C front end and slave controller.
//  Revision: 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam logic        I2C_IDLE_LEVEL         = 1'b1;
    localparam logic [6:0]  DEVICE_ADDR            = 7'b0101010;
    localparam int unsigned FILTER_LEN_DEFAULT     = 3;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 50000;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module  : i2c_glitch_filter
//  Brief   : Two-flop synchroniser plus run-length glitch filter for one line.
//  Revision: 1.0 - initial release
// ============================================================================
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_filt
);

    localparam logic [3:0] c_cnt_max = 4'(FILTER_LEN - 1);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_filt;
    logic       w_differs;

    assign w_differs = r_sync[1] ^ r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{I2C_IDLE_LEVEL}};
            r_cnt  <= '0;
            r_filt <= I2C_IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[0], line_in};
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                // New level has now been stable for FILTER_LEN cycles
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign line_filt = r_filt;

endmodule : i2c_glitch_filter
`default_nettype wire

// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
//  Module  : i2c_bus_conditioner
//  Brief   : Filtered SDA/SCL, SCL edge strobes, START/STOP detection and
//            bus-busy tracking with an SCL-stuck-low timeout.
//  Revision: 1.0 - initial release
// ============================================================================
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEFAULT,
    parameter int unsigned TIMEOUT_W      = 16,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sda_in,
    input  logic scl_in,
    output logic sda_filt,
    output logic scl_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic rstart,
    output logic stop_det,
    output logic bus_busy,
    output logic timeout
);

    localparam logic [TIMEOUT_W-1:0] c_to_max = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic                 w_sda_filt, w_scl_filt;
    logic                 r_sda_q, r_scl_q;
    logic                 r_scl_rise, r_scl_fall;
    logic                 r_start_det, r_rstart, r_stop_det;
    logic                 r_bus_busy, r_timeout;
    logic [TIMEOUT_W-1:0] r_to_cnt;
    logic                 w_scl_stable_hi, w_scl_edge;
    logic                 w_start, w_stop, w_to_hit;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (sda_in),
        .line_filt (w_sda_filt)
    );

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (scl_in),
        .line_filt (w_scl_filt)
    );

    // An SCL edge in the same cycle as an SDA edge masks START/STOP
    assign w_scl_stable_hi = w_scl_filt & r_scl_q;
    assign w_scl_edge      = w_scl_filt ^ r_scl_q;
    assign w_start         = w_scl_stable_hi & ~w_sda_filt &  r_sda_q;
    assign w_stop          = w_scl_stable_hi &  w_sda_filt & ~r_sda_q;
    assign w_to_hit        = r_bus_busy & ~w_scl_filt & ~w_scl_edge
                           & (r_to_cnt == c_to_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_q     <= I2C_IDLE_LEVEL;
            r_scl_q     <= I2C_IDLE_LEVEL;
            r_scl_rise  <= 1'b0;
            r_scl_fall  <= 1'b0;
            r_start_det <= 1'b0;
            r_rstart    <= 1'b0;
            r_stop_det  <= 1'b0;
            r_bus_busy  <= 1'b0;
            r_timeout   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_sda_q     <= w_sda_filt;
            r_scl_q     <= w_scl_filt;
            r_scl_rise  <= w_scl_filt & ~r_scl_q;
            r_scl_fall  <= ~w_scl_filt & r_scl_q;
            r_start_det <= w_start;
            r_rstart    <= w_start & r_bus_busy;
            r_stop_det  <= w_stop;
            r_timeout   <= w_to_hit & ~w_stop;

            if (w_start) begin
                r_bus_busy <= 1'b1;
            end else if (w_stop || w_to_hit) begin
                r_bus_busy <= 1'b0;
            end

            if (!r_bus_busy || w_scl_filt || w_scl_edge || w_to_hit) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign sda_filt  = w_sda_filt;
    assign scl_filt  = w_scl_filt;
    assign scl_rise  = r_scl_rise;
    assign scl_fall  = r_scl_fall;
    assign start_det = r_start_det;
    assign rstart    = r_rstart;
    assign stop_det  = r_stop_det;
    assign bus_busy  = r_bus_busy;
    assign timeout   = r_timeout;

endmodule : i2c_bus_conditioner
`default_nettype wire
